// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter
// Frame-granular round-robin arbiter in front of the RGMII MAC tx_axis port.
// A grant is held from the first beat of a frame through its tlast, so frames
// from different requesters are never interleaved. Arbitration costs one idle
// cycle per frame. Once a grant is held, the data path adds no latency.
//
// Optional feature, enabled by defining ETH_TX_ARB_MAXLEN_EN:
//   Frames are limited to MAX_FRAME_LEN beats. The beat that hits the limit is
//   forced to tlast=1 and tuser=1, and trunc_err pulses. The remainder of the
//   source frame is then drained (DROP) without being forwarded.
//   When the macro is undefined, trunc_err is tied to 0 and frames of any
//   length pass through.
module eth_tx_frame_arbiter #(
    parameter int  NUM_REQ       = 3,
    parameter int  MAX_FRAME_LEN = 1522,
    localparam int IDW           = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ*8-1:0] s_axis_tdata,
    input  logic [NUM_REQ-1:0]   s_axis_tvalid,
    input  logic [NUM_REQ-1:0]   s_axis_tlast,
    input  logic [NUM_REQ-1:0]   s_axis_tuser,
    output logic [NUM_REQ-1:0]   s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    input  logic                 m_axis_tready,
    output logic                 grant_valid,
    output logic [IDW-1:0]       grant_id,
    output logic                 frame_done,
    output logic                 trunc_err
);

    localparam logic [1:0]     ST_IDLE = 2'd0;
    localparam logic [1:0]     ST_PASS = 2'd1;
`ifdef ETH_TX_ARB_MAXLEN_EN
    localparam logic [1:0]     ST_DROP = 2'd2;
    localparam logic [15:0]    LIMIT_M1 = 16'(MAX_FRAME_LEN - 1);
`endif
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_FRAME_LEN < 1 || MAX_FRAME_LEN > 65535) begin : g_param_check
        $error("eth_tx_frame_arbiter: parameter out of range");
    end

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] arb_id;
    logic [IDW-1:0] next_ptr;
    logic           arb_found;
    int unsigned    gi;
    int unsigned    scan_idx;
    logic           src_valid;
    logic           src_last;
    logic           src_user;
    logic [7:0]     src_data;
    logic           trunc_hit;
    logic           out_beat;
`ifdef ETH_TX_ARB_MAXLEN_EN
    logic [15:0]    beat_cnt;
`endif

    assign out_beat = m_axis_tvalid && m_axis_tready;
    assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    // Round-robin scan: first valid requester at or after rr_ptr, with wrap-around
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!arb_found && s_axis_tvalid[scan_idx]) begin
                arb_found = 1'b1;
                arb_id    = IDW'(scan_idx);
            end
        end
    end

    // Granted-source mux and per-state drive of the ready vector and output stream
    always_comb begin
        gi            = 32'(grant_id);
        src_data      = s_axis_tdata[gi*8 +: 8];
        src_valid     = s_axis_tvalid[gi];
        src_last      = s_axis_tlast[gi];
        src_user      = s_axis_tuser[gi];
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        trunc_hit     = 1'b0;
        case (state)
            ST_PASS: begin
                s_axis_tready[gi] = m_axis_tready;
                m_axis_tdata      = src_data;
                m_axis_tvalid     = src_valid;
                m_axis_tlast      = src_last;
                m_axis_tuser      = src_user;
`ifdef ETH_TX_ARB_MAXLEN_EN
                // Beat number MAX_FRAME_LEN without its own tlast closes the frame as bad
                if (beat_cnt == LIMIT_M1 && !src_last) begin
                    m_axis_tlast = 1'b1;
                    m_axis_tuser = 1'b1;
                    trunc_hit    = 1'b1;
                end
`endif
            end
`ifdef ETH_TX_ARB_MAXLEN_EN
            ST_DROP: begin
                s_axis_tready[gi] = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    // Grant FSM: arbitrate in IDLE, hold the grant until the frame's last beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        grant_id    <= arb_id;
                        grant_valid <= 1'b1;
                        state       <= ST_PASS;
                    end
                end
                ST_PASS: begin
`ifdef ETH_TX_ARB_MAXLEN_EN
                    if (out_beat && trunc_hit) begin
                        state <= ST_DROP;
                    end else
`endif
                    if (out_beat && m_axis_tlast) begin
                        state       <= ST_IDLE;
                        grant_valid <= 1'b0;
                        rr_ptr      <= next_ptr;
                        frame_done  <= 1'b1;
                    end
                end
`ifdef ETH_TX_ARB_MAXLEN_EN
                ST_DROP: begin
                    if (src_valid && src_last) begin
                        state       <= ST_IDLE;
                        grant_valid <= 1'b0;
                        rr_ptr      <= next_ptr;
                        frame_done  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state       <= ST_IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ETH_TX_ARB_MAXLEN_EN
    // Beat counter (cleared while idle, so it starts at zero on grant) and truncation pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            trunc_err <= 1'b0;
        end else begin
            trunc_err <= out_beat && trunc_hit;
            if (state == ST_IDLE) begin
                beat_cnt <= '0;
            end else if (out_beat) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
        end
    end
`else
    assign trunc_err = 1'b0;
`endif

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Testbench for eth_tx_frame_arbiter: directed scenarios plus randomized frames.
// The reference model works at the frame/beat level. Each requester owns a
// queue of beats. Ownership follows the round-robin rule, and the expected
// output stream is taken from the owner's queue.
module tb_eth_tx_frame_arbiter;

    localparam int N = 3;
`ifdef ETH_TX_ARB_MAXLEN_EN
    localparam int MAXLEN = 100;
`else
    localparam int MAXLEN = 1522;
`endif
    localparam int IDW = $clog2(N);

    logic           clk;
    logic           rst_n;
    logic [N*8-1:0] s_axis_tdata;
    logic [N-1:0]   s_axis_tvalid;
    logic [N-1:0]   s_axis_tlast;
    logic [N-1:0]   s_axis_tuser;
    logic [N-1:0]   s_axis_tready;
    logic [7:0]     m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic           m_axis_tuser;
    logic           m_axis_tready;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic           frame_done;
    logic           trunc_err;

    eth_tx_frame_arbiter #(
        .NUM_REQ       (N),
        .MAX_FRAME_LEN (MAXLEN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .frame_done    (frame_done),
        .trunc_err     (trunc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-requester beat queues: data, last, user, idle cycles before the beat
    logic [7:0] dq [N][$];
    bit         lq [N][$];
    bit         uq [N][$];
    int         gq [N][$];

    int vectors = 0;
    int errors  = 0;

    int owner;
    int rr;
    int beats;
    bit dropping;
    bit exp_fd;
    bit exp_te;
    bit model_known;
    bit gid_chk;
    int exp_gid;
    int mode;
    bit tog;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit src_ok(input int i);
        return dq[i].size() > 0 && gq[i][0] == 0;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (dq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit trunc_now(input int i);
`ifdef ETH_TX_ARB_MAXLEN_EN
        return (beats + 1 == MAXLEN) && !lq[i][0];
`else
        return 1'b0;
`endif
    endfunction

    task automatic pop(input int i);
        void'(dq[i].pop_front());
        void'(lq[i].pop_front());
        void'(uq[i].pop_front());
        void'(gq[i].pop_front());
    endtask

    task automatic add_frame(input int r, input int len, input int gap_at, input int gap_len);
        for (int b = 0; b < len; b++) begin
            dq[r].push_back(8'($urandom));
            lq[r].push_back(b == len - 1);
            uq[r].push_back(1'($urandom));
            gq[r].push_back(b == gap_at ? gap_len : 0);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            s_axis_tvalid[i]      = src_ok(i);
            s_axis_tdata[i*8 +: 8] = dq[i].size() > 0 ? dq[i][0] : 8'($urandom);
            s_axis_tlast[i]       = dq[i].size() > 0 ? lq[i][0] : 1'b0;
            s_axis_tuser[i]       = dq[i].size() > 0 ? uq[i][0] : 1'b0;
        end
        if (mode == 0) m_axis_tready = 1'b1;
        else if (mode == 1) begin tog = ~tog; m_axis_tready = tog; end
        else m_axis_tready = ($urandom % 4) != 0;
    endtask

    task automatic finish_frame();
        exp_fd   = 1'b1;
        rr       = (owner + 1) % N;
        owner    = -1;
        dropping = 1'b0;
        gid_chk  = 1'b0;
    endtask

    // One clock: check outputs at negedge, advance the model, drive next inputs
    task automatic step();
        logic [N-1:0] exp_rdy;
        bit ev, tr, lst;
        @(negedge clk);
        if (model_known) begin
            chk("grant_valid", grant_valid, owner >= 0);
            if (gid_chk) chk("grant_id", grant_id, exp_gid);
            exp_rdy = '0;
            if (owner >= 0) exp_rdy[owner] = dropping ? 1'b1 : m_axis_tready;
            chk("s_tready", s_axis_tready, exp_rdy);
            ev = owner >= 0 && !dropping && src_ok(owner);
            chk("m_tvalid", m_axis_tvalid, ev);
            if (ev) begin
                tr = trunc_now(owner);
                chk("m_tdata", m_axis_tdata, dq[owner][0]);
                chk("m_tlast", m_axis_tlast, lq[owner][0] | tr);
                chk("m_tuser", m_axis_tuser, uq[owner][0] | tr);
            end
            chk("frame_done", frame_done, exp_fd);
            chk("trunc_err", trunc_err, exp_te);
        end
        if (!rst_n) begin
            owner = -1; rr = 0; dropping = 0; exp_fd = 0; exp_te = 0;
            model_known = 1; gid_chk = 1; exp_gid = 0; beats = 0;
        end else if (model_known) begin
            exp_fd = 0;
            exp_te = 0;
            if (owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (owner < 0 && src_ok((rr + k) % N)) owner = (rr + k) % N;
                end
                if (owner >= 0) begin
                    beats = 0; gid_chk = 1; exp_gid = owner;
                end
            end else if (dropping) begin
                if (src_ok(owner)) begin
                    lst = lq[owner][0];
                    pop(owner);
                    if (lst) finish_frame();
                end
            end else if (src_ok(owner) && m_axis_tready) begin
                tr  = trunc_now(owner);
                lst = lq[owner][0];
                pop(owner);
                beats++;
                if (tr) begin
                    dropping = 1; exp_te = 1;
                end else if (lst) finish_frame();
            end
        end
        for (int i = 0; i < N; i++) begin
            if (dq[i].size() > 0 && gq[i][0] > 0) gq[i][0] = gq[i][0] - 1;
        end
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic run_until_idle(input int max);
        int n;
        n = 0;
        while ((pending() || owner >= 0) && n < max) begin
            step();
            n++;
        end
        step();
        step();
        chk("drain_budget", 32'(n >= max), 0);
    endtask

    initial begin
        int n;
        bit lst;
        rst_n = 1'b0; mode = 0; tog = 0; m_axis_tready = 1'b1;
        owner = -1; rr = 0; beats = 0; dropping = 0; exp_fd = 0; exp_te = 0;
        model_known = 0; gid_chk = 0; exp_gid = 0;
        s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0;

        // Contention with all requesters valid at reset: order 0,1,2,0
        add_frame(0, 6 + int'($urandom % 6), -1, 0);
        add_frame(1, 6 + int'($urandom % 6), -1, 0);
        add_frame(2, 6 + int'($urandom % 6), -1, 0);
        add_frame(0, 6 + int'($urandom % 6), -1, 0);
        drive_inputs();
        step();
        step();
        rst_n = 1'b1;
        run_until_idle(200);

        // Single 64-byte frame from requester 1
        add_frame(1, 64, -1, 0);
        drive_inputs();
        run_until_idle(200);

        // Backpressure on a 20-byte frame; pointer now at 2 so requester 2 wins over 0
        mode = 1;
        add_frame(2, 20, -1, 0);
        add_frame(0, 5, -1, 0);
        drive_inputs();
        run_until_idle(200);
        mode = 0;

        // Mid-frame gap of 5 cycles on the granted requester while requester 2 waits
        add_frame(1, 16, 7, 5);
        add_frame(2, 8, -1, 0);
        drive_inputs();
        run_until_idle(200);

        // Reset at byte 10 of requester 1's frame; arbitration restarts at requester 0
        add_frame(0, 4, -1, 0);
        drive_inputs();
        run_until_idle(100);
        add_frame(1, 30, -1, 0);
        drive_inputs();
        n = 0;
        while (!(owner == 1 && beats == 10) && n < 100) begin
            step();
            n++;
        end
        chk("reset_reach_budget", 32'(n >= 100), 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        lst = 0;
        while (!lst && dq[1].size() > 0) begin
            lst = lq[1][0];
            pop(1);
        end
        add_frame(1, 5, -1, 0);
        add_frame(2, 5, -1, 0);
        add_frame(0, 5, -1, 0);
        drive_inputs();
        run_until_idle(200);

        // Long frames: 150 bytes (truncated at the limit when enabled), 100 bytes exactly
        add_frame(0, 150, -1, 0);
        add_frame(1, 100, -1, 0);
        add_frame(2, 10, -1, 0);
        drive_inputs();
        run_until_idle(600);

        // Randomized frames, gaps and backpressure
        mode = 2;
        for (int round = 0; round < 8; round++) begin
            for (int f = 0; f < 5; f++) begin
                add_frame(int'($urandom % N), 1 + int'($urandom % 20),
                          int'($urandom % 24), int'($urandom % 4));
            end
            drive_inputs();
            run_until_idle(2000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
